// File: rtl/uart_link.sv
// rtl/uart_link.sv - UART transceiver with transmit/receive FIFOs and per-byte error flags

module uart_link_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  do_pop;
    logic                  do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents are only observable through count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_link #(
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_rx,
    output logic                       uart_tx,
    input  logic [15:0]                baud_div,
    input  logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [DATA_BITS-1:0]       rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic                       rx_err_frame,
    output logic                       rx_err_parity,
    output logic                       rx_overrun,
    input  logic                       overrun_clear,
    output logic [FIFO_DEPTH_LOG2:0]   tx_count,
    output logic [FIFO_DEPTH_LOG2:0]   rx_count
);
    localparam logic HAS_PARITY = (PARITY != 0);
    localparam logic PAR_ODD    = (PARITY == 2);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

    logic [15:0] baud_eff;
    assign baud_eff = (baud_div < 16'd2) ? 16'd2 : baud_div;

    // ---------------- transmit path ----------------
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_pop;
    logic [2:0]           tx_state;
    logic [15:0]          tx_cnt;
    logic [15:0]          tx_baud;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic [2:0]           tx_bit;
    logic                 tx_line;
    logic                 tx_bit_end;
    logic                 tx_frame_end;

    assign tx_ready = !tx_full;
    assign uart_tx  = tx_line;

    uart_link_fifo #(.WIDTH(DATA_BITS), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .resetn    (reset),
        .push      (tx_valid && !tx_full),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign tx_bit_end   = (tx_cnt == tx_baud - 16'd1);
    assign tx_frame_end = (tx_state == TX_STOP) && tx_bit_end && (tx_bit == LAST_STOP_BIT);
    // Loading the next byte on the last stop cycle gives back-to-back frames with no gap.
    assign tx_pop       = !tx_empty && ((tx_state == TX_IDLE) || tx_frame_end);

    // Transmit FSM: one bit per baud period, line driven from a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_baud  <= 16'd2;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_baud  <= baud_eff;
            tx_shift <= tx_head;
            tx_par   <= (^tx_head) ^ PAR_ODD;
            tx_bit   <= '0;
            tx_line  <= 1'b0;
        end else if (tx_state != TX_IDLE) begin
            if (!tx_bit_end) begin
                tx_cnt <= tx_cnt + 16'd1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        tx_line  <= tx_shift[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == LAST_DATA_BIT) begin
                            tx_bit <= '0;
                            if (HAS_PARITY) begin
                                tx_state <= TX_PARITY;
                                tx_line  <= tx_par;
                            end else begin
                                tx_state <= TX_STOP;
                                tx_line  <= 1'b1;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_line  <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        tx_bit   <= '0;
                        tx_line  <= 1'b1;
                    end
                    TX_STOP: begin
                        if (tx_bit == LAST_STOP_BIT) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end
                    default: begin
                        tx_state <= TX_IDLE;
                        tx_line  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- receive path ----------------
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic [2:0]           rx_state;
    logic [15:0]          rx_cnt;
    logic [15:0]          rx_baud;
    logic [DATA_BITS-1:0] rx_shift;
    logic [2:0]           rx_bit;
    logic                 rx_perr;
    logic                 rx_sample;
    logic                 rx_push;
    logic                 rx_full;
    logic                 rx_empty;
    logic [DATA_BITS+1:0] rx_head;

    // Two-flop synchroniser plus one more stage for falling-edge detection; idle-high reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // The start check lands half a bit in; every later sample is one full bit after the last.
    assign rx_sample = (rx_state == RX_START) ? (rx_cnt == (rx_baud >> 1)) : (rx_cnt == rx_baud);
    assign rx_push   = (rx_state == RX_STOP) && rx_sample;

    // Receive FSM. A falling edge needs a high sample before it, so after a framing
    // error with the line still low no new frame starts until the line has gone high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_baud  <= 16'd2;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_perr  <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            if (rx_prev && !rx_s2) begin
                rx_state <= RX_START;
                rx_cnt   <= 16'd1;
                rx_baud  <= baud_eff;
                rx_bit   <= '0;
                rx_perr  <= 1'b0;
            end
        end else begin
            rx_cnt <= rx_sample ? 16'd1 : rx_cnt + 16'd1;
            if (rx_sample) begin
                case (rx_state)
                    RX_START: begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: begin
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == LAST_DATA_BIT) begin
                            rx_bit   <= '0;
                            rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end
                    RX_PARITY: begin
                        rx_perr  <= rx_s2 ^ (^rx_shift) ^ PAR_ODD;
                        rx_state <= RX_STOP;
                    end
                    default: begin
                        rx_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    uart_link_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .resetn    (reset),
        .push      (rx_push),
        .push_data ({!rx_s2, rx_perr, rx_shift}),
        .pop       (rx_ready),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign rx_valid      = !rx_empty;
    assign rx_data       = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
    assign rx_err_parity = rx_valid && rx_head[DATA_BITS];
    assign rx_err_frame  = rx_valid && rx_head[DATA_BITS+1];

    // Sticky overrun: a byte lost to a full FIFO with no pop that cycle; set beats clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_overrun <= 1'b0;
        end else if (rx_push && rx_full && !rx_ready) begin
            rx_overrun <= 1'b1;
        end else if (overrun_clear) begin
            rx_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_link.sv
// tb/tb_uart_link.sv - directed self-checking bench for uart_link

module tb_uart_link;
    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx_line;
    logic        uart_tx;
    logic [15:0] baud_div;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_err_frame;
    logic        rx_err_parity;
    logic        rx_overrun;
    logic        overrun_clear;
    logic [2:0]  tx_count;
    logic [2:0]  rx_count;
    logic        loop_en;
    logic        drv_rx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign uart_rx_line = loop_en ? uart_tx : drv_rx;

    uart_link #(
        .DATA_BITS       (8),
        .PARITY          (1),
        .STOP_BITS       (1),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx_line),
        .uart_tx       (uart_tx),
        .baud_div      (baud_div),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_err_frame  (rx_err_frame),
        .rx_err_parity (rx_err_parity),
        .rx_overrun    (rx_overrun),
        .overrun_clear (overrun_clear),
        .tx_count      (tx_count),
        .rx_count      (rx_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Drive one 8-bit frame on drv_rx at 8 clocks per bit, followed by idle high.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        drv_rx = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            drv_rx = d[i];
            repeat (8) tick();
        end
        drv_rx = pbit;
        repeat (8) tick();
        drv_rx = sbit;
        repeat (8) tick();
        drv_rx = 1'b1;
        repeat (16) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_uart_tx got=%0b exp=1", uart_tx); end
        checks++;
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%0b exp=1", tx_ready); end
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
        checks++;
        if ({rx_err_frame, rx_err_parity} !== 2'b00) begin
            failures++; $display("FAIL reset_err_flags got=%b exp=00", {rx_err_frame, rx_err_parity});
        end
        checks++;
        if (rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", rx_overrun); end
        checks++;
        if (tx_count !== 3'd0 || rx_count !== 3'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", tx_count, rx_count);
        end
        checks++;
        if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    endtask

    // 0xA5, even parity, 4 clocks per bit; baud_div changed mid-frame must not matter.
    task automatic test_tx_frame();
        int exp_bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        baud_div = 16'd4;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++;
        if (tx_count !== 3'd1) begin failures++; $display("FAIL tx_push_count got=%0d exp=1", tx_count); end
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL tx_pre_start got=%0b exp=1", uart_tx); end
        for (int k = 0; k < 44; k++) begin
            tick();
            if (k == 5) baud_div = 16'd9;
            checks++;
            if (uart_tx !== exp_bits[k/4][0]) begin
                failures++; $display("FAIL tx_bit cycle=%0d got=%0b exp=%0d", k, uart_tx, exp_bits[k/4]);
            end
        end
        baud_div = 16'd4;
        tick();
        checks++;
        if (uart_tx !== 1'b1 || tx_count !== 3'd0) begin
            failures++; $display("FAIL tx_idle_after got=%0b/%0d exp=1/0", uart_tx, tx_count);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
        int         waited;
        baud_div = 16'd4;
        loop_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data  = bytes[i];
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        waited = 0;
        while (rx_count != 3'd3 && waited < 500) begin
            tick();
            waited++;
        end
        checks++;
        if (rx_count !== 3'd3) begin failures++; $display("FAIL loop_rx_count got=%0d exp=3", rx_count); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== bytes[i] || rx_err_frame !== 1'b0 || rx_err_parity !== 1'b0) begin
                failures++;
                $display("FAIL loop_byte%0d got=v%0b d=%h f%0b p%0b exp=v1 d=%h f0 p0",
                         i, rx_valid, rx_data, rx_err_frame, rx_err_parity, bytes[i]);
            end
            pop_one();
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
            failures++; $display("FAIL loop_drained got=v%0b o%0b exp=v0 o0", rx_valid, rx_overrun);
        end
        repeat (20) tick();
        loop_en = 1'b0;
    endtask

    task automatic test_glitch();
        baud_div = 16'd8;
        drv_rx   = 1'b0;
        tick();
        drv_rx = 1'b1;
        repeat (40) tick();
        checks++;
        if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
            failures++; $display("FAIL glitch_no_push got=%0d/%0b exp=0/0", rx_count, rx_valid);
        end
    endtask

    task automatic test_rx_errors();
        baud_div = 16'd8;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1);
        checks++;
        if (rx_count !== 3'd2) begin failures++; $display("FAIL err_rx_count got=%0d exp=2", rx_count); end
        checks++;
        if (rx_data !== 8'h5A || rx_err_frame !== 1'b1 || rx_err_parity !== 1'b0) begin
            failures++;
            $display("FAIL err_frame_entry got=d%h f%0b p%0b exp=d5a f1 p0", rx_data, rx_err_frame, rx_err_parity);
        end
        pop_one();
        checks++;
        if (rx_data !== 8'h81 || rx_err_frame !== 1'b0 || rx_err_parity !== 1'b1) begin
            failures++;
            $display("FAIL err_parity_entry got=d%h f%0b p%0b exp=d81 f0 p1", rx_data, rx_err_frame, rx_err_parity);
        end
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        baud_div = 16'd8;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(bytes[i], ^bytes[i], 1'b1);
        checks++;
        if (rx_count !== 3'd4 || rx_overrun !== 1'b0) begin
            failures++; $display("FAIL ovr_full_no_flag got=%0d/%0b exp=4/0", rx_count, rx_overrun);
        end
        send_frame(bytes[4], ^bytes[4], 1'b1);
        checks++;
        if (rx_count !== 3'd4 || rx_overrun !== 1'b1) begin
            failures++; $display("FAIL ovr_flag got=%0d/%0b exp=4/1", rx_count, rx_overrun);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data !== bytes[i] || rx_err_frame !== 1'b0 || rx_err_parity !== 1'b0) begin
                failures++;
                $display("FAIL ovr_byte%0d got=d%h f%0b p%0b exp=d%h f0 p0",
                         i, rx_data, rx_err_frame, rx_err_parity, bytes[i]);
            end
            pop_one();
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_overrun !== 1'b1) begin
            failures++; $display("FAIL ovr_sticky got=v%0b o%0b exp=v0 o1", rx_valid, rx_overrun);
        end
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        checks++;
        if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", rx_overrun); end
    endtask

    // Overfill the tx FIFO (sixth push dropped), then reset in the middle of a frame.
    task automatic test_full_drop_reset();
        baud_div = 16'd4;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (6) tick();
        tx_valid = 1'b0;
        checks++;
        if (tx_count !== 3'd4 || tx_ready !== 1'b0) begin
            failures++; $display("FAIL full_drop got=%0d/%0b exp=4/0", tx_count, tx_ready);
        end
        repeat (4) tick();
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL mid_tx_line got=%0b exp=0", uart_tx); end
        reset = 1'b0;
        tick();
        checks++;
        if (uart_tx !== 1'b1 || tx_count !== 3'd0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_tx got=tx%0b c%0d r%0b exp=tx1 c0 r1", uart_tx, tx_count, tx_ready);
        end
        reset = 1'b1;
        repeat (8) tick();
        checks++;
        if (uart_tx !== 1'b1 || tx_count !== 3'd0) begin
            failures++; $display("FAIL post_reset_idle got=%0b/%0d exp=1/0", uart_tx, tx_count);
        end
    endtask

    initial begin
        reset         = 1'b0;
        baud_div      = 16'd4;
        tx_data       = 8'h00;
        tx_valid      = 1'b0;
        rx_ready      = 1'b0;
        overrun_clear = 1'b0;
        loop_en       = 1'b0;
        drv_rx        = 1'b1;
        test_reset();
        test_tx_frame();
        test_loopback();
        test_glitch();
        test_rx_errors();
        test_overrun();
        test_full_drop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_link.md
UART_LINK -- requirements
Module: uart_link

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..8.
REQ-002 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per transmitted frame; legal values 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH_LOG2, default 4, meaning each FIFO holds 2**FIFO_DEPTH_LOG2 entries.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  system clock; reset  in  1  synchronous active-low reset.
REQ-006 SHALL have port uart_rx  in  1  asynchronous serial input.
REQ-007 SHALL have port uart_tx  out  1  serial output.
REQ-008 SHALL have port baud_div  in  16  clk cycles per bit.
REQ-009 SHALL have ports tx_data  in  DATA_BITS, tx_valid  in  1, tx_ready  out  1, forming the transmit push handshake.
REQ-010 SHALL have ports rx_data  out  DATA_BITS, rx_valid  out  1, rx_ready  in  1, forming the receive pop handshake.
REQ-011 SHALL have ports rx_err_frame  out  1 and rx_err_parity  out  1, the error flags of the current rx head entry.
REQ-012 SHALL have ports rx_overrun  out  1 (sticky lost-byte flag) and overrun_clear  in  1.
REQ-013 SHALL have ports tx_count  out  FIFO_DEPTH_LOG2+1 and rx_count  out  FIFO_DEPTH_LOG2+1, the FIFO occupancies.

Function
REQ-014 SHALL complete a transfer on either handshake in each cycle where valid and ready are both high; tx_ready = tx FIFO not full; rx_valid = rx FIFO not empty.
REQ-015 SHALL present the rx FIFO first-word fall-through: rx_data, rx_err_frame and rx_err_parity reflect the head entry whenever rx_valid is high.
REQ-016 SHALL, when the tx FIFO is full, drop any tx_valid without changing state.
REQ-017 SHALL latch baud_div at each frame start (both directions) and treat values below 2 as 2; a mid-frame change has no effect until the next frame.
REQ-018 SHALL run the TX FSM as IDLE -> START -> DATA -> PARITY (PARITY!=0 only) -> STOP -> IDLE, holding each bit for exactly baud_div cycles.
REQ-019 SHALL, in IDLE with the tx FIFO non-empty, pop the FIFO and drive the start bit (0) on the following cycle.
REQ-020 SHALL send DATA bits LSB first; parity bit = XOR of data (even) or its inverse (odd); STOP drives 1 for STOP_BITS*baud_div cycles.
REQ-021 SHALL start back-to-back frames with no idle gap.
REQ-022 SHALL pass uart_rx through a 2-flop synchroniser whose flops reset to 1.
REQ-023 SHALL run the RX FSM as IDLE -> START_CHECK -> DATA -> PARITY (PARITY!=0 only) -> STOP -> IDLE.
REQ-024 SHALL, on a synchronised falling edge in IDLE, wait baud_div/2 (floor) cycles, then return to IDLE if the line is high (glitch) or continue if low.
REQ-025 SHALL sample each subsequent bit baud_div cycles after the previous sample point; one stop bit is always checked regardless of STOP_BITS.
REQ-026 SHALL set the entry's err_parity on a parity mismatch and its err_frame on a stop sample of 0; erroneous bytes are still pushed.
REQ-027 SHALL push the byte at the stop sample point; if the rx FIFO is full it discards the byte and sets rx_overrun.
REQ-028 SHALL treat a pop and a push in the same cycle on a full rx FIFO as a successful push with no overrun.
REQ-029 SHALL hold rx_overrun until overrun_clear; if a set and a clear coincide, the set wins.
REQ-030 SHALL, when a frame ends with err_frame, return RX to IDLE and require a line-high sample before it accepts a new falling edge.

Reset
REQ-031 SHALL, while reset=0 at a clk edge, empty both FIFOs, force both FSMs to IDLE and abort any frame in progress.
REQ-032 SHALL, after reset, drive uart_tx=1, tx_ready=1, rx_valid=0, rx_err_frame=0, rx_err_parity=0, rx_overrun=0, tx_count=0, rx_count=0, with rx_data=0.

Verification
REQ-033 SHALL be verified with baud_div=4, PARITY=1, push 0xA5 -> uart_tx 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles, 44 cycles total.
REQ-034 SHALL be verified with uart_tx looped to uart_rx, pushing 0x00, 0xFF, 0x3C back-to-back -> same three bytes popped in order, no error flags set.
REQ-035 SHALL be verified with a 1-cycle low glitch on idle uart_rx at baud_div=8 -> no push, rx_count stays 0.
REQ-036 SHALL be verified with FIFO_DEPTH_LOG2=2, rx_ready=0 and 5 frames received -> rx_count=4, rx_overrun=1, the first 4 bytes are intact, and overrun_clear clears the flag.
REQ-037 SHALL be verified with a frame received with stop=0 and with wrong parity -> the entries carry err_frame=1 and err_parity=1 respectively.
REQ-038 SHALL be verified with reset asserted mid-transmit -> uart_tx=1 on the next cycle, tx_count=0, tx_ready=1.
